// File: rtl/ccip_c1_tx_arbiter_pkg.sv
// Shared types for the CCI-P c1 TX arbiter.
//   t_ccip_clLen        : CCI-P cache-line length encoding of a multi-line write
//   t_ccip_c1_ReqMemHdr : c1 write request header (reduced to the fields this block uses)
//   t_if_ccip_c1_Tx     : one c1 beat (header, 512-bit data, valid)
//   arb_state_e         : arbiter FSM states
//   cl_len_to_beats()   : beats in a packet for a given cl_len
package ccip_c1_tx_arbiter_pkg;

  localparam int unsigned CcipClDataWidth = 512;
  // Largest batch; also the free-space threshold for src_ready.
  localparam int unsigned MaxBeats = 4;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_3 = 2'b10,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [3:0]  req_type;
    logic        sop;
    t_ccip_clLen cl_len;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr         hdr;
    logic [CcipClDataWidth-1:0] data;
    logic                       valid;
  } t_if_ccip_c1_Tx;

  typedef enum logic {
    ArbIdle,
    ArbBurst
  } arb_state_e;

  // eCL_LEN_3 is not a legal length; callers must flag it as a protocol error.
  function automatic logic [2:0] cl_len_to_beats(input t_ccip_clLen cl_len);
    logic [2:0] beats;
    case (cl_len)
      eCL_LEN_1: beats = 3'd1;
      eCL_LEN_2: beats = 3'd2;
      eCL_LEN_4: beats = 3'd4;
      default:   beats = 3'd3;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ccip_c1_tx_arbiter_if.sv
// Bus bundle between the c1 write sources, the arbiter and the CCI-P c1 channel.
//   sTx_c1_in       : per-source beats, qualified by .valid, no backpressure
//   src_ready       : per-source "FIFO has room for a full batch" (registered)
//   sRx_c1TxAlmFull : CCI-P c1 almost-full
//   sTx_c1          : merged registered beat towards CCI-P
//   error           : sticky overflow / protocol-violation flag
//   drop_cnt        : saturating count of dropped beats
// master = sources/shell side, slave = arbiter.
interface ccip_c1_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 2
);
  import ccip_c1_tx_arbiter_pkg::*;

  t_if_ccip_c1_Tx [NUM_SRC-1:0] sTx_c1_in;
  logic [NUM_SRC-1:0]           src_ready;
  logic                         sRx_c1TxAlmFull;
  t_if_ccip_c1_Tx               sTx_c1;
  logic                         error;
  logic [15:0]                  drop_cnt;

  modport master (
    output sTx_c1_in,
    output sRx_c1TxAlmFull,
    input  src_ready,
    input  sTx_c1,
    input  error,
    input  drop_cnt
  );

  modport slave (
    input  sTx_c1_in,
    input  sRx_c1TxAlmFull,
    output src_ready,
    output sTx_c1,
    output error,
    output drop_cnt
  );

endinterface

// File: rtl/ccip_c1_tx_arbiter_fifo.sv
// Synchronous per-source skid FIFO holding whole c1 beats.
//   clk_i, rst_i : clock, synchronous active-high reset (flushes contents)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (valid only when count_o != 0)
//   count_o      : occupancy, LDepth+1 bits
//   full_o       : count_o == 2**LDepth
module ccip_c1_tx_arbiter_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned LDepth = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  head_o,
  output logic [LDepth:0]   count_o,
  output logic              full_o
);

  localparam int unsigned Depth = 2 ** LDepth;
  localparam int unsigned CntW  = LDepth + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [LDepth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + LDepth'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + LDepth'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ccip_c1_tx_arbiter.sv
// Merges NUM_SRC c1 write streams (source 0 = CCI-P transmitter) onto one sTx_c1 channel.
// Each source feeds its own skid FIFO; a round-robin FSM picks a source only once its whole
// packet (1/2/4 beats) is buffered, then drains that packet on consecutive cycles so
// multi-line batches stay contiguous. New picks wait for !sRx_c1TxAlmFull; bursts in progress
// do not. Overflow drops and malformed head beats raise the sticky error and bump drop_cnt.
//   clk    : clock
//   reset  : synchronous, active-high
//   bus_io : slave side of ccip_c1_tx_arbiter_if (sources in, merged beat and status out)
module ccip_c1_tx_arbiter
  import ccip_c1_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned LFIFO_DEPTH = 3
) (
  input logic                 clk,
  input logic                 reset,
  ccip_c1_tx_arbiter_if.slave bus_io
);

  localparam int unsigned     BeatW     = $bits(t_if_ccip_c1_Tx);
  localparam int unsigned     Depth     = 2 ** LFIFO_DEPTH;
  localparam int unsigned     CntW      = LFIFO_DEPTH + 1;
  localparam int unsigned     SrcW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CntW-1:0] DepthCnt  = CntW'(Depth);
  localparam logic [CntW-1:0] ReadyFree = CntW'(MaxBeats);

  // A 4-line batch must fit, or it could never become eligible.
  if (Depth < MaxBeats) begin : gen_depth_check
    $error("ccip_c1_tx_arbiter: 2**LFIFO_DEPTH must be >= 4");
  end

  logic [BeatW-1:0]   head_raw [NUM_SRC];
  t_if_ccip_c1_Tx     head     [NUM_SRC];
  logic [CntW-1:0]    count    [NUM_SRC];
  logic [2:0]         head_len [NUM_SRC];
  logic [NUM_SRC-1:0] full, push, drop_push, pop, discard, bad_head, eligible;

  arb_state_e         state_q, state_d;
  logic [SrcW-1:0]    rr_q, rr_d;
  logic [SrcW-1:0]    src_q, src_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         beat_cnt_q, beat_cnt_d;
  t_if_ccip_c1_Tx     out_q, out_d;
  logic               error_q, error_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [NUM_SRC-1:0] src_ready_q, src_ready_d;

  // Per-source FIFO, push/drop and head classification.
  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_src
    assign push[g]      = bus_io.sTx_c1_in[g].valid & ~full[g];
    assign drop_push[g] = bus_io.sTx_c1_in[g].valid & full[g];

    ccip_c1_tx_arbiter_fifo #(
      .Width  (BeatW),
      .LDepth (LFIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push[g]),
      .wdata_i (bus_io.sTx_c1_in[g]),
      .pop_i   (pop[g]),
      .head_o  (head_raw[g]),
      .count_o (count[g]),
      .full_o  (full[g])
    );

    assign head[g]     = t_if_ccip_c1_Tx'(head_raw[g]);
    assign head_len[g] = cl_len_to_beats(head[g].hdr.cl_len);
    // A packet must start with sop and carry a legal length.
    assign bad_head[g] = (count[g] != '0) &&
                         (!head[g].hdr.sop || head[g].hdr.cl_len == eCL_LEN_3);
    assign eligible[g] = (count[g] != '0) && !bad_head[g] &&
                         (count[g] >= CntW'(head_len[g]));
  end

  // Arbiter FSM next state, FIFO pops and next output beat.
  always_comb begin
    logic            found;
    logic [SrcW-1:0] pick;
    int unsigned     idx;

    state_d    = state_q;
    rr_d       = rr_q;
    src_d      = src_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    out_d      = '0;
    pop        = '0;
    discard    = '0;
    found      = 1'b0;
    pick       = '0;
    idx        = 0;

    unique case (state_q)
      ArbIdle: begin
        // Malformed heads are flushed regardless of AlmFull so they cannot block a source.
        discard = bad_head;
        if (!bus_io.sRx_c1TxAlmFull) begin
          for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_q) + k) % NUM_SRC;
            if (!found && eligible[SrcW'(idx)]) begin
              found = 1'b1;
              pick  = SrcW'(idx);
            end
          end
        end
        pop = discard;
        if (found) begin
          pop[pick]   = 1'b1;
          out_d       = head[pick];
          out_d.valid = 1'b1;
          src_d       = pick;
          len_d       = head_len[pick];
          beat_cnt_d  = 3'd1;
          rr_d        = SrcW'((32'(pick) + 1) % NUM_SRC);
          if (head_len[pick] != 3'd1) state_d = ArbBurst;
        end
      end
      ArbBurst: begin
        // Whole packet was buffered at pick time, so the head is always present here.
        pop[src_q]  = 1'b1;
        out_d       = head[src_q];
        out_d.valid = 1'b1;
        beat_cnt_d  = beat_cnt_q + 3'd1;
        if (beat_cnt_q == len_q - 3'd1) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Statistics and registered ready.
  always_comb begin
    logic [16:0] drop_sum;
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      drop_sum = drop_sum + 17'(drop_push[s]) + 17'(discard[s]);
    end
    drop_cnt_d = (drop_sum > 17'h0_FFFF) ? 16'hFFFF : drop_sum[15:0];
    error_d    = error_q | (|drop_push) | (|discard);
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      src_ready_d[s] = (DepthCnt - count[s]) >= ReadyFree;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ArbIdle;
      rr_q        <= '0;
      src_q       <= '0;
      len_q       <= 3'd1;
      beat_cnt_q  <= '0;
      out_q       <= '0;
      error_q     <= 1'b0;
      drop_cnt_q  <= '0;
      src_ready_q <= '1;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      src_q       <= src_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      out_q       <= out_d;
      error_q     <= error_d;
      drop_cnt_q  <= drop_cnt_d;
      src_ready_q <= src_ready_d;
    end
  end

  assign bus_io.sTx_c1    = out_q;
  assign bus_io.src_ready = src_ready_q;
  assign bus_io.error     = error_q;
  assign bus_io.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ccip_c1_tx_arbiter.sv
// Directed bench for ccip_c1_tx_arbiter (NUM_SRC=2, LFIFO_DEPTH=3).
// Row k of the table is driven before clock edge k and its expectations are sampled 1 time
// unit after that edge. A beat pushed at edge k can be picked at edge k+1 and is then on
// sTx_c1 until edge k+2.
module tb_ccip_c1_tx_arbiter;
  import ccip_c1_tx_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ccip_c1_tx_arbiter_if #(.NUM_SRC(2)) bus_if ();

  ccip_c1_tx_arbiter #(
    .NUM_SRC     (2),
    .LFIFO_DEPTH (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_if.slave)
  );

  always #5 clk = ~clk;

  // {sop, cl_len} codes for a beat.
  localparam logic [2:0] S1 = 3'b100;  // sop, 1 line
  localparam logic [2:0] S2 = 3'b101;  // sop, 2 lines
  localparam logic [2:0] S4 = 3'b111;  // sop, 4 lines
  localparam logic [2:0] M2 = 3'b001;  // continuation of a 2-line batch
  localparam logic [2:0] M4 = 3'b011;  // continuation of a 4-line batch
  localparam logic [2:0] N1 = 3'b000;  // missing sop
  localparam logic [2:0] L3 = 3'b110;  // illegal eCL_LEN_3

  // Address 0 means "no beat" on input and "valid=0 expected" on output.
  typedef struct {
    logic [15:0] a0;
    logic [2:0]  c0;
    logic [15:0] a1;
    logic [2:0]  c1;
    logic        alm;
    logic [15:0] ea;
    logic        eerr;
    logic [15:0] edrop;
  } vec_t;

  localparam int NumVec = 39;
  vec_t tbl [NumVec];

  function automatic vec_t row(input logic [15:0] a0, input logic [2:0] c0,
                               input logic [15:0] a1, input logic [2:0] c1, input logic alm,
                               input logic [15:0] ea, input logic eerr,
                               input logic [15:0] edrop);
    vec_t v;
    v.a0 = a0; v.c0 = c0; v.a1 = a1; v.c1 = c1; v.alm = alm;
    v.ea = ea; v.eerr = eerr; v.edrop = edrop;
    return v;
  endfunction

  function automatic t_if_ccip_c1_Tx mk_beat(input logic [15:0] a, input logic [2:0] code);
    t_if_ccip_c1_Tx b;
    b                = '0;
    b.valid          = (a != 16'h0);
    b.hdr.sop        = code[2];
    b.hdr.cl_len     = t_ccip_clLen'(code[1:0]);
    b.hdr.address    = 42'(a);
    b.hdr.mdata      = a ^ 16'h5a5a;
    b.data[31:0]     = {~a, a};
    b.data[511:496]  = a;
    return b;
  endfunction

  // Fingerprint of a beat built by mk_beat with address a.
  function automatic logic [63:0] exp_sig(input logic [15:0] a);
    return {a, a ^ 16'h5a5a, ~a, a};
  endfunction

  function automatic logic [63:0] got_sig();
    return {bus_if.sTx_c1.hdr.address[15:0], bus_if.sTx_c1.hdr.mdata, bus_if.sTx_c1.data[31:0]};
  endfunction

  task automatic drive(input logic [15:0] a0, input logic [2:0] c0,
                       input logic [15:0] a1, input logic [2:0] c1, input logic alm);
    bus_if.sTx_c1_in[0]    = mk_beat(a0, c0);
    bus_if.sTx_c1_in[1]    = mk_beat(a1, c1);
    bus_if.sRx_c1TxAlmFull = alm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Checks the output beat: valid, and when a beat is expected, its content.
  task automatic check_out(input string name, input logic [15:0] ea);
    check({name, ".valid"}, 64'(bus_if.sTx_c1.valid), 64'(ea != 16'h0));
    if (ea != 16'h0) check({name, ".beat"}, got_sig(), exp_sig(ea));
  endtask

  initial begin
    // 4-line batch from src0, then a 1-line packet from src1 to move rr_ptr back to 0.
    tbl[0]  = row(16'h100, S4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[1]  = row(16'h101, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[2]  = row(16'h102, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[3]  = row(16'h103, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[4]  = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h100, 1'b0, 16'd0);
    tbl[5]  = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h101, 1'b0, 16'd0);
    tbl[6]  = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h102, 1'b0, 16'd0);
    tbl[7]  = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h103, 1'b0, 16'd0);
    tbl[8]  = row(16'h0,   N1, 16'h200, S1,   1'b0, 16'h0,   1'b0, 16'd0);
    tbl[9]  = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h200, 1'b0, 16'd0);
    // Both sources hold a 2-line batch; rr_ptr=0 so src0 first, no interleaving.
    tbl[10] = row(16'h110, S2, 16'h210, S2,   1'b0, 16'h0,   1'b0, 16'd0);
    tbl[11] = row(16'h111, M2, 16'h211, M2,   1'b0, 16'h0,   1'b0, 16'd0);
    tbl[12] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h110, 1'b0, 16'd0);
    tbl[13] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h111, 1'b0, 16'd0);
    tbl[14] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h210, 1'b0, 16'd0);
    tbl[15] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h211, 1'b0, 16'd0);
    // AlmFull holds a ready 1-line packet on src1.
    tbl[16] = row(16'h0,   N1, 16'h220, S1,   1'b1, 16'h0,   1'b0, 16'd0);
    tbl[17] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h0,   1'b0, 16'd0);
    tbl[18] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h0,   1'b0, 16'd0);
    tbl[19] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h220, 1'b0, 16'd0);
    // AlmFull rises mid-burst: burst completes, src1 packet waits for AlmFull=0.
    tbl[20] = row(16'h130, S4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[21] = row(16'h131, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[22] = row(16'h132, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[23] = row(16'h133, M4, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[24] = row(16'h0,   N1, 16'h240, S1,   1'b0, 16'h130, 1'b0, 16'd0);
    tbl[25] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h131, 1'b0, 16'd0);
    tbl[26] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h132, 1'b0, 16'd0);
    tbl[27] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h133, 1'b0, 16'd0);
    tbl[28] = row(16'h0,   N1, 16'h0,   3'b0, 1'b1, 16'h0,   1'b0, 16'd0);
    tbl[29] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h240, 1'b0, 16'd0);
    // Head without sop is discarded while the next good beat is pushed on the same edge.
    tbl[30] = row(16'h150, N1, 16'h0,   3'b0, 1'b0, 16'h0,   1'b0, 16'd0);
    tbl[31] = row(16'h151, S1, 16'h0,   3'b0, 1'b0, 16'h0,   1'b1, 16'd1);
    tbl[32] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h151, 1'b1, 16'd1);
    // eCL_LEN_3 head is discarded; then a contest with rr_ptr=1 favours src1.
    tbl[33] = row(16'h0,   N1, 16'h260, L3,   1'b0, 16'h0,   1'b1, 16'd1);
    tbl[34] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h0,   1'b1, 16'd2);
    tbl[35] = row(16'h170, S1, 16'h270, S1,   1'b0, 16'h0,   1'b1, 16'd2);
    tbl[36] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h270, 1'b1, 16'd2);
    tbl[37] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h170, 1'b1, 16'd2);
    tbl[38] = row(16'h0,   N1, 16'h0,   3'b0, 1'b0, 16'h0,   1'b1, 16'd2);

    // Reset state.
    drive(16'h0, N1, 16'h0, N1, 1'b0);
    reset = 1'b1;
    repeat (3) step();
    check("rst.valid",     64'(bus_if.sTx_c1.valid), 64'd0);
    check("rst.src_ready", 64'(bus_if.src_ready),    64'h3);
    check("rst.error",     64'(bus_if.error),        64'd0);
    check("rst.drop_cnt",  64'(bus_if.drop_cnt),     64'd0);
    reset = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      drive(tbl[i].a0, tbl[i].c0, tbl[i].a1, tbl[i].c1, tbl[i].alm);
      step();
      check_out($sformatf("row%0d", i), tbl[i].ea);
      check($sformatf("row%0d.error", i), 64'(bus_if.error), 64'(tbl[i].eerr));
      check($sformatf("row%0d.drop_cnt", i), 64'(bus_if.drop_cnt), 64'(tbl[i].edrop));
    end

    // Reset in the middle of a 4-line burst abandons it and flushes the FIFO.
    drive(16'h180, S4, 16'h0, N1, 1'b0); step();
    drive(16'h181, M4, 16'h0, N1, 1'b0); step();
    drive(16'h182, M4, 16'h0, N1, 1'b0); step();
    drive(16'h183, M4, 16'h0, N1, 1'b0); step();
    drive(16'h0, N1, 16'h0, N1, 1'b0);
    step();
    check_out("burst.b0", 16'h180);
    step();
    check_out("burst.b1", 16'h181);
    reset = 1'b1;
    step();
    check("midrst.valid",     64'(bus_if.sTx_c1.valid), 64'd0);
    check("midrst.error",     64'(bus_if.error),        64'd0);
    check("midrst.drop_cnt",  64'(bus_if.drop_cnt),     64'd0);
    check("midrst.src_ready", 64'(bus_if.src_ready),    64'h3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("postrst%0d", i), 16'h0);
    end

    // Overflow: 9 one-line packets into a depth-8 FIFO while AlmFull holds them.
    for (int i = 1; i <= 9; i++) begin
      drive(16'h300 + 16'(i - 1), S1, 16'h0, N1, 1'b1);
      step();
      // src_ready lags the count by one edge: after push i it reflects count i-1.
      check($sformatf("ovf%0d.src_ready", i), 64'(bus_if.src_ready),
            64'({1'b1, (i - 1) <= 4}));
      check($sformatf("ovf%0d.valid", i), 64'(bus_if.sTx_c1.valid), 64'd0);
      check($sformatf("ovf%0d.error", i), 64'(bus_if.error), 64'(i == 9));
      check($sformatf("ovf%0d.drop_cnt", i), 64'(bus_if.drop_cnt), 64'(i == 9));
    end
    drive(16'h0, N1, 16'h0, N1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step();
      check_out($sformatf("drain%0d", j), 16'h300 + 16'(j));
    end
    step();
    check_out("drain.end", 16'h0);
    check("drain.drop_cnt", 64'(bus_if.drop_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
